reg_file_sweep: RTL

Parametrised successor to the CPU register file: one write port, two read ports, with configurable data width and depth. Reads are registered with write-to-read bypass. Adds an optional hardwired-zero register 0 and a multi-cycle CLEAR sweep engine that zeroes the array one entry per cycle without asserting reset. Sits between instruction decode, which supplies the addresses, and the ALU/writeback path.

---
 rtl/reg_file_sweep.sv | 99 +++++++++
 1 files changed

// File: rtl/reg_file_sweep.sv
// Register file with one write port, two registered read ports, write-to-read bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle CLEAR sweep engine.
module reg_file_sweep #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITEENABLE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              BUSY,
  output logic              DONE,
  output logic              WRITE_DROP
);

  localparam int unsigned       DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q, done_q, drop_q;
  logic [DATA_W-1:0] out1_q, out2_q;
  logic [DATA_W-1:0] out1_d, out2_d;
  logic              wr_en;
  logic              sweep_wr;

  assign sweep_wr = (state_q == SWEEP);
  assign wr_en    = WRITEENABLE && !busy_q && !(ZERO_REG && (INADDRESS == '0));

  // Read value as it will stand after this edge: sweep zeroing and host writes
  // are mutually exclusive, so their bypass order does not matter.
  function automatic logic [DATA_W-1:0] rd_next(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && (a == '0))     return '0;
    if (sweep_wr && (a == cnt_q))  return '0;
    if (wr_en && (a == INADDRESS)) return IN;
    return mem_q[a];
  endfunction

  always_comb begin
    out1_d = rd_next(OUT1ADDRESS);
    out2_d = rd_next(OUT2ADDRESS);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= WRITEENABLE && busy_q;
      out1_q <= out1_d;
      out2_q <= out2_d;
      if (wr_en) mem_q[INADDRESS] <= IN;
      case (state_q)
        IDLE: begin
          if (CLEAR) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT1       = out1_q;
  assign OUT2       = out2_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign WRITE_DROP = drop_q;

endmodule
